// File: rtl/gray_fifo_rd_ctrl_8.sv
// Read-side controller for the 8-entry async FIFO in the 25G PCS clock crossing.
// Synchronizes the write pointer (8-state gray code), derives empty/level, drives
// the RAM read port and returns the read pointer in the same code to the write side.
module gray_fifo_rd_ctrl_8 #(
  parameter int unsigned DW          = 66,
  parameter int unsigned SYNC_STAGES = 2  // 2 or 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [4:0]    wptr_gray_async,
  input  logic          rd_req,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_rd_en,
  output logic [2:0]    mem_rd_addr,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [4:0]    rptr_gray,
  output logic          empty,
  output logic [2:0]    level,
  output logic          code_err
);

  // Code table: index 0..7 -> 00000 00001 00011 00010 00110 00111 00101 00100
  function automatic logic [4:0] gray_enc(input logic [2:0] idx);
    logic [4:0] code;
    case (idx)
      3'd0:    code = 5'b00000;
      3'd1:    code = 5'b00001;
      3'd2:    code = 5'b00011;
      3'd3:    code = 5'b00010;
      3'd4:    code = 5'b00110;
      3'd5:    code = 5'b00111;
      3'd6:    code = 5'b00101;
      default: code = 5'b00100;
    endcase
    return code;
  endfunction

  // Returns {legal, index}; index is don't-care when the code is not in the table.
  function automatic logic [3:0] gray_dec(input logic [4:0] code);
    logic [3:0] res;
    case (code)
      5'b00000: res = {1'b1, 3'd0};
      5'b00001: res = {1'b1, 3'd1};
      5'b00011: res = {1'b1, 3'd2};
      5'b00010: res = {1'b1, 3'd3};
      5'b00110: res = {1'b1, 3'd4};
      5'b00111: res = {1'b1, 3'd5};
      5'b00101: res = {1'b1, 3'd6};
      5'b00100: res = {1'b1, 3'd7};
      default:  res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  logic [4:0] sync_q [SYNC_STAGES];
  logic [2:0] wbin_q;   // last legal decoded write index
  logic [2:0] rbin_q;
  logic [2:0] wbin;
  logic       w_legal;
  logic [2:0] w_idx;
  logic [2:0] rbin_inc;

  // Plain flop chain on the async pointer, no logic between stages.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'b00000;
    end else begin
      sync_q[0] <= wptr_gray_async;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Decode the synchronized pointer and derive occupancy and the pop strobe.
  always_comb begin
    {w_legal, w_idx} = gray_dec(sync_q[SYNC_STAGES-1]);
    // An illegal code must never move the write index; hold the last good one.
    wbin      = w_legal ? w_idx : wbin_q;
    level     = wbin - rbin_q;
    empty     = (level == 3'd0);
    mem_rd_en = rd_req & ~empty;
    rbin_inc  = rbin_q + 3'd1;
    dout      = mem_rdata;
  end

  // Read pointer, RAM address, data-valid and sticky error state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wbin_q      <= 3'd0;
      rbin_q      <= 3'd0;
      rptr_gray   <= 5'b00000;
      mem_rd_addr <= 3'd0;
      dout_valid  <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      wbin_q     <= wbin;
      dout_valid <= mem_rd_en;
      if (!w_legal) code_err <= 1'b1;
      if (mem_rd_en) begin
        rbin_q      <= rbin_inc;
        rptr_gray   <= gray_enc(rbin_inc);
        mem_rd_addr <= rbin_inc;
      end
    end
  end

endmodule

// File: tb/tb_gray_fifo_rd_ctrl_8.sv
// Self-checking bench for gray_fifo_rd_ctrl_8: cycle reference model plus a
// scoreboard of expected read words matched against dout when dout_valid rises.
module tb_gray_fifo_rd_ctrl_8;
  localparam int unsigned DW = 66;
  localparam int unsigned S  = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4:0]    wptr_gray_async;
  logic          rd_req;
  logic [DW-1:0] mem_rdata;
  logic          mem_rd_en;
  logic [2:0]    mem_rd_addr;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic [4:0]    rptr_gray;
  logic          empty;
  logic [2:0]    level;
  logic          code_err;

  gray_fifo_rd_ctrl_8 #(.DW(DW), .SYNC_STAGES(S)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .wptr_gray_async (wptr_gray_async),
    .rd_req          (rd_req),
    .mem_rdata       (mem_rdata),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .dout            (dout),
    .dout_valid      (dout_valid),
    .rptr_gray       (rptr_gray),
    .empty           (empty),
    .level           (level),
    .code_err        (code_err)
  );

  always #5 clk = ~clk;

  // RAM model with one cycle read latency.
  logic [DW-1:0] ram [8];
  always_ff @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_rd_addr];

  localparam logic [4:0] CODES [8] = '{5'b00000, 5'b00001, 5'b00011, 5'b00010,
                                       5'b00110, 5'b00111, 5'b00101, 5'b00100};

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state.
  logic [4:0]    m_hist [S];
  logic [2:0]    m_wb_hold;
  logic [2:0]    m_rb;
  logic          m_err;
  logic          m_dv;
  bit            m_valid = 1'b0;
  logic [DW-1:0] sb [$];

  function automatic logic [3:0] lookup(input logic [4:0] c);
    for (int k = 0; k < 8; k++) if (CODES[k] == c) return {1'b1, 3'(k)};
    return 4'b0000;
  endfunction

  // One clock cycle: apply inputs, check against the model, advance the model.
  task automatic tick(input logic rst_n, input logic [4:0] w, input logic rd);
    logic [3:0] dec;
    logic [2:0] wb, lvl;
    logic       emp, en;
    reset_n = rst_n; wptr_gray_async = w; rd_req = rd;
    #1;
    if (m_valid) begin
      dec = lookup(m_hist[S-1]);
      wb  = dec[3] ? dec[2:0] : m_wb_hold;
      lvl = wb - m_rb;
      emp = (lvl == 3'd0);
      en  = rd & ~emp;
      check_eq("level", level, lvl);
      check_eq("empty", empty, emp);
      check_eq("mem_rd_en", mem_rd_en, en);
      check_eq("mem_rd_addr", mem_rd_addr, m_rb);
      check_eq("rptr_gray", rptr_gray, CODES[m_rb]);
      check_eq("dout_valid", dout_valid, m_dv);
      check_eq("code_err", code_err, m_err);
      if (dout_valid === 1'b1) begin
        if (sb.size() == 0) check_eq("dout_unexpected", dout_valid, 1'b0);
        else check_eq("dout", dout, sb.pop_front());
      end
      if (rst_n) begin
        if (en) sb.push_back(ram[m_rb]);
        for (int k = S - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = w;
        m_wb_hold = wb;
        if (!dec[3]) m_err = 1'b1;
        if (en) m_rb = m_rb + 3'd1;
        m_dv = en;
      end
    end
    if (!rst_n) begin
      for (int k = 0; k < S; k++) m_hist[k] = 5'b00000;
      m_wb_hold = 3'd0; m_rb = 3'd0; m_err = 1'b0; m_dv = 1'b0;
      sb.delete();
      m_valid = 1'b1;
    end
    @(negedge clk);
  endtask

  logic [2:0] w_idx;
  logic [2:0] room;

  initial begin
    for (int k = 0; k < 8; k++) ram[k] = {2'($urandom), 32'($urandom), 32'($urandom)};
    reset_n = 1'b0; wptr_gray_async = 5'b00000; rd_req = 1'b0;
    @(negedge clk);

    // Reset with a stale pointer at the input; it must surface only after sync.
    tick(1'b0, 5'b00110, 1'b0);
    tick(1'b0, 5'b00110, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 5'b00110, 1'b0);
    check_eq("reset_then_level4", level, 3'd4);

    // Sync latency from a clean reset.
    tick(1'b0, 5'b00000, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 5'b00001, 1'b0);
    check_eq("sync_level1", level, 3'd1);

    // Move rbin to 6, then wrap the write pointer to index 1 and drain.
    w_idx = 3'd6;
    for (int i = 0; i < 3; i++) tick(1'b1, CODES[w_idx], 1'b0);
    for (int i = 0; i < 6; i++) tick(1'b1, CODES[w_idx], 1'b1);
    tick(1'b1, CODES[w_idx], 1'b0);
    for (int i = 0; i < 3; i++) begin
      w_idx = w_idx + 3'd1;
      tick(1'b1, CODES[w_idx], 1'b0);
    end
    for (int i = 0; i < 3; i++) tick(1'b1, CODES[w_idx], 1'b0);
    check_eq("wrap_level3", level, 3'd3);
    check_eq("wrap_addr6", mem_rd_addr, 3'd6);
    for (int i = 0; i < 5; i++) tick(1'b1, CODES[w_idx], 1'b1);
    check_eq("wrap_empty", empty, 1'b1);
    check_eq("wrap_rptr", rptr_gray, 5'b00001);

    // Pop requests while empty.
    for (int i = 0; i < 4; i++) tick(1'b1, CODES[w_idx], 1'b1);
    check_eq("empty_pop_addr", mem_rd_addr, 3'd1);

    // Illegal synchronized code for one cycle.
    tick(1'b0, 5'b00011, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 5'b00011, 1'b0);
    tick(1'b1, 5'b11111, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 5'b00011, 1'b0);
    check_eq("illegal_level", level, 3'd2);
    check_eq("illegal_err", code_err, 1'b1);

    // Full occupancy then drain; reset must also clear code_err.
    tick(1'b0, 5'b00100, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 5'b00100, 1'b0);
    check_eq("full_level7", level, 3'd7);
    check_eq("err_cleared", code_err, 1'b0);
    for (int i = 0; i < 9; i++) tick(1'b1, 5'b00100, 1'b1);
    check_eq("full_drained", empty, 1'b1);

    // Random traffic within the 7-entry bound.
    tick(1'b0, 5'b00000, 1'b0);
    w_idx = 3'd0;
    for (int i = 0; i < 300; i++) begin
      room = w_idx + 3'd1 - m_rb;
      if (room != 3'd0 && $urandom_range(0, 1) == 1) w_idx = w_idx + 3'd1;
      tick(1'b1, CODES[w_idx], 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 12; i++) tick(1'b1, CODES[w_idx], 1'b1);
    check_eq("final_empty", empty, 1'b1);
    check_eq("sb_drained", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
